// File: rtl/bc_decode_pkg.sv
// rtl/bc_decode_pkg.sv - shared types, constants and RGB565 expansion for the BCn decoder
// Purpose: block geometry constants, format enum, RGBA8 texel struct and
//          the RGB565 -> RGB8 bit-replication helper.
package bc_decode_pkg;

  localparam int TEXELS  = 16;
  localparam int BLOCK_W = 128;

  typedef enum logic {
    FMT_BC1 = 1'b0,
    FMT_BC3 = 1'b1
  } bc_fmt_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [7:0] a;
  } rgba8_t;

  // Alpha defaults to opaque; callers override it where needed.
  function automatic rgba8_t expand565(input logic [15:0] c);
    rgba8_t p;
    p.r = {c[15:11], c[15:13]};
    p.g = {c[10:5], c[10:9]};
    p.b = {c[4:0], c[4:2]};
    p.a = 8'hFF;
    return p;
  endfunction

endpackage

// File: rtl/bc_alpha_palette.sv
// rtl/bc_alpha_palette.sv - combinational BC3 eight-entry alpha palette
// Purpose: builds the 8 alpha values of a BC3 alpha sub-block from its endpoints.
// Ports:
//   i_a0, i_a1 : alpha endpoints
//   o_alpha    : palette, entry c is the alpha for 3-bit code c
module bc_alpha_palette (
  input  logic [7:0]      i_a0,
  input  logic [7:0]      i_a1,
  output logic [7:0][7:0] o_alpha
);

  always_comb begin
    o_alpha    = '0;
    o_alpha[0] = i_a0;
    o_alpha[1] = i_a1;
    if (i_a0 > i_a1) begin
      // Eight-level ramp: six interpolated steps between the endpoints.
      for (int c = 2; c < 8; c++) begin
        o_alpha[3'(c)] = 8'(((8 - c) * int'(i_a0) + (c - 1) * int'(i_a1)) / 7);
      end
    end else begin
      // Six-level ramp plus explicit fully transparent / fully opaque codes.
      for (int c = 2; c < 6; c++) begin
        o_alpha[3'(c)] = 8'(((6 - c) * int'(i_a0) + (c - 1) * int'(i_a1)) / 5);
      end
      o_alpha[6] = 8'h00;
      o_alpha[7] = 8'hFF;
    end
  end

endmodule

// File: rtl/bc_block_decoder.sv
// rtl/bc_block_decoder.sv - BC1/BC3 4x4 block decoder emitting RGBA8 texels per beat
// Purpose: accepts one compressed block per handshake, registers its palettes
//          and index fields, then streams 16 texels in row-major order,
//          PIX_PER_CYCLE texels per beat, with no bubbles between blocks.
// Ports:
//   i_clk, i_rst              : clock, synchronous active-high reset
//   i_in_valid / o_in_ready   : input handshake
//   i_in_block, i_in_fmt      : compressed block, 0 = BC1, 1 = BC3
//   i_in_tag                  : sideband tag carried to the output
//   o_out_valid / i_out_ready : output handshake
//   o_out_rgba                : lane j at [32j+31:32j] as {R,G,B,A}
//   o_out_idx                 : texel index of lane 0
//   o_out_last, o_out_tag     : final-beat flag, tag of the block being emitted
module bc_block_decoder
  import bc_decode_pkg::*;
#(
  parameter int PIX_PER_CYCLE = 4,
  parameter int TAG_W         = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_in_valid,
  output logic                       o_in_ready,
  input  logic [BLOCK_W-1:0]         i_in_block,
  input  logic                       i_in_fmt,
  input  logic [TAG_W-1:0]           i_in_tag,
  output logic                       o_out_valid,
  input  logic                       i_out_ready,
  output logic [32*PIX_PER_CYCLE-1:0] o_out_rgba,
  output logic [3:0]                 o_out_idx,
  output logic                       o_out_last,
  output logic [TAG_W-1:0]           o_out_tag
);

  localparam int         BEATS  = TEXELS / PIX_PER_CYCLE;
  localparam logic [3:0] LAST_K = 4'(BEATS - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } state_e;

  state_e           r_state, w_state_nxt;
  logic [3:0]       r_k, w_k_nxt;
  rgba8_t [3:0]     r_pal;
  logic [7:0][7:0]  r_apal;
  logic [31:0]      r_cidx;
  logic [47:0]      r_aidx;
  logic             r_bc3;
  logic [TAG_W-1:0] r_tag;

  logic             w_bc3, w_four, w_last_beat, w_accept, w_fire;
  logic [63:0]      w_col;
  logic [15:0]      w_c0, w_c1;
  rgba8_t           w_p0, w_p1, w_px;
  rgba8_t [3:0]     w_pal;
  logic [7:0][7:0]  w_apal;
  logic [3:0]       w_tex;

  // (2x + y) / 3 with a 10-bit intermediate, truncating.
  function automatic logic [7:0] third(input logic [7:0] x, input logic [7:0] y);
    logic [9:0] s;
    s = {2'b00, x} + {2'b00, x} + {2'b00, y};
    return 8'(s / 10'd3);
  endfunction

  function automatic logic [7:0] half(input logic [7:0] x, input logic [7:0] y);
    logic [8:0] s;
    s = {1'b0, x} + {1'b0, y};
    return s[8:1];
  endfunction

  // ---------------- palette construction from the offered block ----------------
  assign w_bc3  = (i_in_fmt == FMT_BC3);
  assign w_col  = w_bc3 ? i_in_block[127:64] : i_in_block[63:0];
  assign w_c0   = w_col[15:0];
  assign w_c1   = w_col[31:16];
  // BC3 colour never uses punch-through; its alpha comes from the alpha palette.
  assign w_four = w_bc3 || (w_c0 > w_c1);

  always_comb begin
    w_p0     = expand565(w_c0);
    w_p1     = expand565(w_c1);
    w_pal[0] = w_p0;
    w_pal[1] = w_p1;
    if (w_four) begin
      w_pal[2].r = third(w_p0.r, w_p1.r);
      w_pal[2].g = third(w_p0.g, w_p1.g);
      w_pal[2].b = third(w_p0.b, w_p1.b);
      w_pal[2].a = 8'hFF;
      w_pal[3].r = third(w_p1.r, w_p0.r);
      w_pal[3].g = third(w_p1.g, w_p0.g);
      w_pal[3].b = third(w_p1.b, w_p0.b);
      w_pal[3].a = 8'hFF;
    end else begin
      w_pal[2].r = half(w_p0.r, w_p1.r);
      w_pal[2].g = half(w_p0.g, w_p1.g);
      w_pal[2].b = half(w_p0.b, w_p1.b);
      w_pal[2].a = 8'hFF;
      w_pal[3]   = '0;
    end
  end

  bc_alpha_palette u_alpha (
    .i_a0    (i_in_block[7:0]),
    .i_a1    (i_in_block[15:8]),
    .o_alpha (w_apal)
  );

  // ---------------- handshake and beat sequencing ----------------
  assign w_last_beat = (r_state == S_EMIT) && (r_k == LAST_K);
  assign o_in_ready  = (r_state == S_IDLE) || (w_last_beat && i_out_ready);
  assign o_out_valid = (r_state == S_EMIT);
  assign w_fire      = o_out_valid && i_out_ready;
  assign w_accept    = i_in_valid && o_in_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_EMIT;
          w_k_nxt     = '0;
        end
      end
      S_EMIT: begin
        if (w_fire) begin
          if (w_last_beat) begin
            // A block accepted alongside the final beat starts with no bubble.
            w_state_nxt = w_accept ? S_EMIT : S_IDLE;
            w_k_nxt     = '0;
          end else begin
            w_k_nxt = r_k + 4'd1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_k_nxt     = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_pal   <= '0;
      r_apal  <= '0;
      r_cidx  <= '0;
      r_aidx  <= '0;
      r_bc3   <= 1'b0;
      r_tag   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_k     <= w_k_nxt;
      if (w_accept) begin
        r_pal  <= w_pal;
        r_apal <= w_apal;
        r_cidx <= w_col[63:32];
        r_aidx <= i_in_block[63:16];
        r_bc3  <= w_bc3;
        r_tag  <= i_in_tag;
      end
    end
  end

  // ---------------- per-lane texel lookup ----------------
  always_comb begin
    o_out_rgba = '0;
    w_px       = '0;
    w_tex      = '0;
    for (int j = 0; j < PIX_PER_CYCLE; j++) begin
      w_tex = 4'(int'(r_k) * PIX_PER_CYCLE + j);
      w_px  = r_pal[r_cidx[{w_tex, 1'b0} +: 2]];
      if (r_bc3) begin
        w_px.a = r_apal[r_aidx[6'(w_tex * 3) +: 3]];
      end
      o_out_rgba[32*j +: 32] = w_px;
    end
  end

  assign o_out_idx  = 4'(int'(r_k) * PIX_PER_CYCLE);
  assign o_out_last = w_last_beat;
  assign o_out_tag  = r_tag;

endmodule
